stme_arbiter: RTL and testbench

STME_ARBITER -- requirements
Module: stme_arbiter

---
 rtl/stme_pkg.sv | 12 +
 rtl/stme_tag_fifo.sv | 56 +++++
 rtl/stme_arbiter.sv | 111 +++++++++++
 tb/tb_stme_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stme_pkg.sv
// Shared types for the two-requester block arbiter in front of the shared 128-bit datapath.
package stme_pkg;
  localparam int BEAT_W = 64;
  localparam int CNT_W  = 4;

  typedef logic req_id_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HI   = 1'b1
  } state_t;
endpackage

// File: rtl/stme_tag_fifo.sv
// In-order FIFO of requester IDs, one entry per block in flight in the datapath.
module stme_tag_fifo
  import stme_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  req_id_t       push_id,
  input  logic          pop,
  output req_id_t       head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  req_id_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a pop frees the slot the same cycle, so a full FIFO can still take a push
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end
endmodule

// File: rtl/stme_arbiter.sv
// Round-robin, block-granular arbiter for two requesters sharing one datapath,
// with credit-limited issue and in-order routing of result beats back to the owner.
module stme_arbiter
  import stme_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int DATA_W          = BEAT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              dp_input_valid,
  output logic [DATA_W-1:0] dp_input_data,
  input  logic              dp_output_valid,
  input  logic [DATA_W-1:0] dp_output_data,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [CNT_W-1:0]  outstanding,
  output logic              error
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [1:0]             req_valid, req_ready, rsp_valid;
  logic [1:0][DATA_W-1:0] rsp_data;
  state_t                 state;
  req_id_t                owner, rr_ptr, winner, head, acc_id;
  logic [CW-1:0]          fifo_cnt;
  logic                   fifo_empty, fifo_full;
  logic                   accept, push, rsp_beat, rsp_hi, pop, credit_ok;
  logic [DATA_W-1:0]      acc_data;

  assign req_valid = {req1_valid, req0_valid};

  assign rsp_beat  = dp_output_valid & ~fifo_empty;
  assign pop       = rsp_beat & rsp_hi;
  // the credit returned by a pop is usable by a new block in the same cycle
  assign credit_ok = ~fifo_full | pop;
  assign winner    = (&req_valid) ? rr_ptr : req_valid[1];

  always_comb begin
    req_ready = '0;
    if (!reset) begin
      if (state == ST_HI)                  req_ready[owner]  = 1'b1;
      else if (|req_valid && credit_ok)    req_ready[winner] = 1'b1;
    end
  end

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];
  assign accept     = |(req_valid & req_ready);
  assign acc_id     = req_ready[1];
  assign acc_data   = acc_id ? req1_data : req0_data;
  assign push       = accept & (state == ST_HI);

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      owner          <= '0;
      rr_ptr         <= '0;
      rsp_hi         <= 1'b0;
      error          <= 1'b0;
      dp_input_valid <= 1'b0;
      dp_input_data  <= '0;
    end else begin
      dp_input_valid <= accept;
      if (accept) begin
        dp_input_data <= acc_data;
        if (state == ST_IDLE) begin
          state <= ST_HI;
          owner <= acc_id;
        end else begin
          state  <= ST_IDLE;
          rr_ptr <= ~rr_ptr;
        end
      end
      if (rsp_beat) rsp_hi <= ~rsp_hi;
      // a result with no tagged block is dropped, only the flag records it
      if (dp_output_valid && fifo_empty) error <= 1'b1;
    end
  end

  stme_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tags (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .push_id (owner),
    .pop     (pop),
    .head    (head),
    .count   (fifo_cnt),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  for (genvar i = 0; i < 2; i++) begin : g_rsp
    assign rsp_valid[i] = ~reset & rsp_beat & (head == req_id_t'(i));
    assign rsp_data[i]  = (head == req_id_t'(i)) ? dp_output_data : '0;
  end

  assign rsp0_valid  = rsp_valid[0];
  assign rsp1_valid  = rsp_valid[1];
  assign rsp0_data   = rsp_data[0];
  assign rsp1_data   = rsp_data[1];
  assign outstanding = CNT_W'(fifo_cnt);
endmodule

// File: tb/tb_stme_arbiter.sv
// Randomized + directed bench for stme_arbiter: queue-based reference model, scoreboard monitor on responses.
module tb_stme_arbiter;
  import stme_pkg::*;

  localparam int MAXO = 4;
  localparam int DW   = 64;
  localparam logic [DW-1:0] XF = 64'h5A5A_5A5A_5A5A_5A5A;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready;
  logic          dp_input_valid;
  logic [DW-1:0] dp_input_data;
  logic          dp_output_valid = 1'b0;
  logic [DW-1:0] dp_output_data = '0;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_data, rsp1_data;
  logic [3:0]    outstanding;
  logic          error;

  always #5 clock = ~clock;

  stme_arbiter #(.MAX_OUTSTANDING(MAXO), .DATA_W(DW)) dut (
    .clock           (clock),
    .reset           (reset),
    .req0_valid      (req0_valid),
    .req0_data       (req0_data),
    .req0_ready      (req0_ready),
    .req1_valid      (req1_valid),
    .req1_data       (req1_data),
    .req1_ready      (req1_ready),
    .dp_input_valid  (dp_input_valid),
    .dp_input_data   (dp_input_data),
    .dp_output_valid (dp_output_valid),
    .dp_output_data  (dp_output_data),
    .rsp0_valid      (rsp0_valid),
    .rsp0_data       (rsp0_data),
    .rsp1_valid      (rsp1_valid),
    .rsp1_data       (rsp1_data),
    .outstanding     (outstanding),
    .error           (error)
  );

  typedef struct { int who; logic [DW-1:0] data; } rsp_t;

  rsp_t          rspq[$];
  logic [DW-1:0] dpq[$];
  int            tagq[$];
  int            obs[$];
  int            n_chk = 0, n_pass = 0;

  // reference model state
  bit            m_hi, m_tog, m_err, prev_acc;
  int            m_owner, m_ptr;
  logic [DW-1:0] prev_data;

  // requester sources and datapath control
  bit [1:0]      want, phase;
  logic [DW-1:0] lo_val [2], hi_val [2];
  int            seq [2];
  bit            ret_en, err_pulse;
  int            ret_pct = 100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic new_block(input int r);
    seq[r]++;
    lo_val[r] = {4'(r), 28'(seq[r]), 32'($urandom())};
    hi_val[r] = {4'(r) | 4'h8, 28'(seq[r]), 32'($urandom())};
  endtask

  // one clock: drive at posedge+1, predict, then compare and advance the model at negedge
  task automatic tick();
    logic [1:0] exp_rdy;
    bit         pop_now, rsp_ok, credit;
    int         w, r;
    @(posedge clock); #1;
    req0_valid = want[0];
    req0_data  = phase[0] ? hi_val[0] : lo_val[0];
    req1_valid = want[1];
    req1_data  = phase[1] ? hi_val[1] : lo_val[1];
    rsp_ok = (tagq.size() > 0);
    dp_output_valid = 1'b0;
    dp_output_data  = '0;
    if (err_pulse) begin
      dp_output_valid = 1'b1;
      dp_output_data  = 64'h0000_0000_0000_DEAD;
    end else if (ret_en && dpq.size() > 0 && $urandom_range(99) < 32'(ret_pct)) begin
      dp_output_valid = 1'b1;
      dp_output_data  = dpq.pop_front();
    end
    if (dp_output_valid && rsp_ok) rspq.push_back('{who: tagq[0], data: dp_output_data});
    pop_now = dp_output_valid && rsp_ok && m_tog;
    exp_rdy = 2'b00;
    if (m_hi) exp_rdy[m_owner] = 1'b1;
    else begin
      credit = (tagq.size() < MAXO) || pop_now;
      if (want == 2'b11)  w = m_ptr;
      else if (want[0])   w = 0;
      else if (want[1])   w = 1;
      else                w = -1;
      if (w >= 0 && credit) exp_rdy[w] = 1'b1;
    end
    @(negedge clock);
    chk("ready", 64'({req1_ready, req0_ready}), 64'(exp_rdy));
    chk("dp_in_valid", 64'(dp_input_valid), 64'(prev_acc));
    if (prev_acc) chk("dp_in_data", dp_input_data, prev_data);
    chk("outstanding", 64'(outstanding), 64'(tagq.size()));
    chk("error", 64'(error), 64'(m_err));
    if (req0_valid && req0_ready) obs.push_back(0);
    if (req1_valid && req1_ready) obs.push_back(1);
    prev_acc = 1'b0;
    if ((exp_rdy & want) != 2'b00) begin
      r = exp_rdy[1] ? 1 : 0;
      prev_acc = 1'b1;
      if (!m_hi) begin
        m_hi = 1'b1; m_owner = r; prev_data = lo_val[r]; phase[r] = 1'b1;
      end else begin
        prev_data = hi_val[r]; m_hi = 1'b0; m_ptr ^= 1;
        tagq.push_back(r);
        dpq.push_back(lo_val[r] ^ XF);
        dpq.push_back(hi_val[r] ^ XF);
        phase[r] = 1'b0;
        new_block(r);
      end
    end
    if (dp_output_valid) begin
      if (!rsp_ok) m_err = 1'b1;
      else if (m_tog) begin void'(tagq.pop_front()); m_tog = 1'b0; end
      else m_tog = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    dp_output_valid = 1'b1; dp_output_data = '1;
    @(posedge clock);
    @(negedge clock);
    chk("rst_ready", 64'({req1_ready, req0_ready}), 64'd0);
    chk("rst_rsp_valid", 64'({rsp1_valid, rsp0_valid}), 64'd0);
    chk("rst_dp_in_valid", 64'(dp_input_valid), 64'd0);
    chk("rst_dp_in_data", dp_input_data, 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    dp_output_valid = 1'b0; dp_output_data = '0;
    rspq.delete(); dpq.delete(); tagq.delete(); obs.delete();
    m_hi = 0; m_tog = 0; m_err = 0; prev_acc = 0; m_owner = 0; m_ptr = 0;
    want = 0; phase = 0; ret_en = 0; err_pulse = 0; ret_pct = 100;
    new_block(0); new_block(1);
  endtask

  task automatic drain();
    want = 2'b00; ret_en = 1'b1; ret_pct = 100;
    for (int i = 0; i < 64 && (dpq.size() > 0 || tagq.size() > 0); i++) tick();
    tick();
    chk("drain_outstanding", 64'(outstanding), 64'd0);
    chk("drain_rsp_pending", 64'(rspq.size()), 64'd0);
  endtask

  // scoreboard monitor: every routed result beat must match the head expectation
  always @(negedge clock) begin
    rsp_t e;
    if (!reset && (rsp0_valid || rsp1_valid)) begin
      if (rspq.size() == 0) begin
        n_chk++;
        $display("FAIL rsp_unexpected: rsp0_valid=%0b rsp1_valid=%0b, nothing expected at %0t",
                 rsp0_valid, rsp1_valid, $time);
      end else begin
        e = rspq.pop_front();
        chk("rsp_route", 64'({rsp1_valid, rsp0_valid}), (e.who == 1) ? 64'd2 : 64'd1);
        chk("rsp_data", (e.who == 1) ? rsp1_data : rsp0_data, e.data);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int pat [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    do_reset();

    // single block from req0
    lo_val[0] = 64'h1; hi_val[0] = 64'h2; want = 2'b01;
    tick(); tick();
    chk("s1_dp_lo", dp_input_data, 64'h1);
    want = 2'b00; tick();
    chk("s1_dp_hi", dp_input_data, 64'h2);
    chk("s1_out_one", 64'(outstanding), 64'd1);
    ret_en = 1'b1;
    tick(); tick(); tick();
    chk("s1_out_zero", 64'(outstanding), 64'd0);

    // contention
    do_reset();
    want = 2'b11; ret_en = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 8; i++)
      chk("s2_order", 64'((i < obs.size()) ? obs[i] : -1), 64'(pat[i]));
    drain();

    // credit limit, then push/pop in the same cycle
    do_reset();
    want = 2'b11; ret_en = 1'b0;
    repeat (12) tick();
    chk("s3_out_full", 64'(outstanding), 64'd4);
    chk("s3_ready_low", 64'({req1_ready, req0_ready}), 64'd0);
    ret_en = 1'b1;
    tick();
    chk("s3_ready_first_beat", 64'({req1_ready, req0_ready}), 64'd0);
    tick();
    chk("s3_ready_on_pop", 64'({req1_ready, req0_ready}), 64'd1);
    want = 2'b00; tick();
    want = 2'b01; tick();
    want = 2'b00; ret_en = 1'b0; tick();
    chk("s4_pushpop", 64'(outstanding), 64'd3);
    drain();

    // mid-block stall by req1
    do_reset();
    want = 2'b10; tick();
    want = 2'b01;
    repeat (5) begin
      tick();
      chk("s5_req0_ready", 64'(req0_ready), 64'd0);
    end
    want = 2'b10; tick();
    want = 2'b00; tick();
    chk("s5_out_one", 64'(outstanding), 64'd1);
    drain();

    // protocol error, then reset during HI
    do_reset();
    err_pulse = 1'b1; tick();
    err_pulse = 1'b0; tick();
    chk("s6_error", 64'(error), 64'd1);
    want = 2'b01; tick();
    want = 2'b00;
    do_reset();
    want = 2'b10; tick(); tick();
    want = 2'b00;
    drain();

    // randomized traffic with periodic datapath stalls
    do_reset();
    ret_pct = 60;
    for (int i = 0; i < 1500; i++) begin
      want   = 2'($urandom_range(3));
      ret_en = ((i % 64) >= 20);
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
